sweep_accumulator: RTL
======================

# sweep_accumulator

Downstream stage of the acquisition sequencer. Consumes each sweep of FIFO samples that the sequencer's `rdreq` bursts release and accumulates them per spectral point over `MEASURES` sweeps in an internal register array. When the last sweep completes, it streams the `NPTS` sums out over a valid/ready port toward the save/transfer stage, then re-arms for the next averaging block.

## Interface
- `NPTS`, 11, samples per sweep (equals sequencer `POINTS`+1, the `rdreq` burst length)
- `MEASURES`, 100, sweeps per averaging block
- `DATA_W`, 14, FIFO sample width, unsigned
- `ACC_W`, 24, accumulator width; must be ≥ `DATA_W` + ceil(log2(`MEASURES`))

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `rdreq`  in  1  FIFO read strobe from sequencer; one high burst per sweep
- `fifo_q`  in  `DATA_W`  FIFO read data, valid the cycle after `rdreq` (non-showahead FIFO)
- `sum_data`  out  `ACC_W`  accumulated sum for `sum_point`
- `sum_point`  out  11  point index of `sum_data`, 0..`NPTS`-1
- `sum_valid`  out  1  output word valid
- `sum_last`  out  1  high with the word for point `NPTS`-1
- `sum_ready`  in  1  downstream accepts the word when high together with `sum_valid`
- `err_len`  out  1  sticky: a sweep delivered other than `NPTS` samples
- `overrun`  out  1  sticky: a sweep arrived during DUMP and was dropped

## Operation
- `s_valid` = `rdreq` registered one cycle. Sample `fifo_q` is taken on every cycle with `s_valid`=1.
- Sweep start: rising edge of `s_valid`. Sweep end: falling edge of `s_valid`.
- Internal `idx` (point index) resets to 0 at sweep start and increments per accepted sample.
- `sweep_cnt`, 0..`MEASURES`-1: increments at each sweep end in ACC.
- States:
  - ACC: per sample with `idx` < `NPTS`: `acc[idx]` <= (`sweep_cnt`==0 ? 0 : `acc[idx]`) + `fifo_q`. The first sweep overwrites, so the array needs no clear. Samples with `idx` ≥ `NPTS` are dropped and set `err_len`. At sweep end, if `idx` != `NPTS`, set `err_len`; the sweep still counts. A sweep end with `sweep_cnt`==`MEASURES`-1 → DUMP, `sweep_cnt` <= 0.
  - DUMP: `rd_idx` starts at 0. Outputs are `sum_valid`=1, `sum_point`=`rd_idx`, `sum_data`=`acc[rd_idx]`, `sum_last`=(`rd_idx`==`NPTS`-1).
    - On `sum_valid`&`sum_ready`, `rd_idx` increments. Acceptance of the last word → ACC.
    - While `sum_ready`=0, all outputs hold stable.
    - A sweep start seen in DUMP drops that entire sweep: no array write, not counted, and `overrun` is set. If the burst is still high when DUMP ends, the rest of that burst stays dropped; accumulation resumes only at the next sweep start.
- Arithmetic: unsigned, `ACC_W` bits, no saturation. The `ACC_W` rule guarantees no wrap.
- Reset values: state ACC; `sweep_cnt`, `idx`, `rd_idx` 0; `sum_valid`, `sum_last`, `err_len`, `overrun` 0; `sum_data`, `sum_point` 0. Array contents are not reset.
- Reset mid-sweep or mid-DUMP discards the partial block. The next complete sweep is treated as sweep 0.
- `err_len` and `overrun` clear only on reset.

## Timing
- Sample latency: `rdreq` high at cycle n → `fifo_q` captured at the edge ending cycle n+1. Array updated at that same edge.
- Sweep end detected the cycle after the last sample. Transition to DUMP happens at that edge, so `sum_valid` rises 2 cycles after the last `rdreq`=1 cycle.
- DUMP with `sum_ready` tied high: `NPTS` consecutive cycles, one word per cycle. `sum_valid` drops the cycle after the last word is accepted.
- Back-to-back sweeps separated by a single `rdreq`=0 cycle must be accumulated correctly.

## Test plan
- Constant sample: `MEASURES`=100, `fifo_q`=0x3FFF every sample, 100 bursts of 11 → 11 words, each `sum_data`=1 638 300, `sum_point` 0..10, `sum_last` only on point 10, no error flags.
- Ramp: sample = `idx` + sweep number (0..99) → `sum_data`[p] = 100·p + 4950 for every p.
- Backpressure: toggle `sum_ready` pseudo-randomly during DUMP → outputs stable while stalled, exactly 11 acceptances, order 0..10.
- Length errors: one burst of 12 samples and one of 10 → `err_len`=1. The 12th sample is not added. Both sweeps are counted, so DUMP still follows the 100th sweep.
- Overrun: hold `sum_ready`=0 and send a burst during DUMP → `overrun`=1. After the dump completes, the next 100 sweeps give correct sums that exclude the dropped sweep.
- Reset: assert `rst_n`=0 for 1 cycle mid-DUMP, then run a second block with `fifo_q`=5 → all outputs 0 during reset, then sums of 500 with no contamination from the first block.

Source files
------------

// File: rtl/sweep_accumulator.sv
// Sums NPTS-sample sweeps over MEASURES sweeps, then streams the NPTS sums out on valid/ready.
// Samples land in the array 1 cycle after rdreq; sum_valid rises 2 cycles after the final rdreq; outputs hold while sum_ready=0.
module sweep_accumulator #(
  parameter int NPTS     = 11,
  parameter int MEASURES = 100,
  parameter int DATA_W   = 14,
  parameter int ACC_W    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdreq,
  input  logic [DATA_W-1:0] fifo_q,
  output logic [ACC_W-1:0]  sum_data,
  output logic [10:0]       sum_point,
  output logic              sum_valid,
  output logic              sum_last,
  input  logic              sum_ready,
  output logic              err_len,
  output logic              overrun
);
  localparam int IDX_W = $clog2(NPTS + 2);
  localparam int CNT_W = (MEASURES > 1) ? $clog2(MEASURES) : 1;

  typedef enum logic {ST_ACC, ST_DUMP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]   eff_idx;
  logic [CNT_W-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic               active_q, active_d;
  logic               err_len_q, err_len_d;
  logic               overrun_q, overrun_d;
  logic               s_valid_q, s_valid_prev_q;
  logic               sweep_start, sweep_end;
  logic [ACC_W-1:0]   acc_q [NPTS];
  logic               acc_we;
  logic [ACC_W-1:0]   acc_wd;

  // The edge that clears s_valid also carries the last sample, so end is seen while s_valid_q is still high.
  assign sweep_start = s_valid_q && !s_valid_prev_q;
  assign sweep_end   = s_valid_q && !rdreq;
  assign eff_idx     = sweep_start ? '0 : idx_q;
  assign acc_wd      = ((sweep_cnt_q == '0) ? '0 : acc_q[eff_idx]) + ACC_W'(fifo_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    sweep_cnt_d = sweep_cnt_q;
    active_d    = active_q;
    err_len_d   = err_len_q;
    overrun_d   = overrun_q;
    acc_we      = 1'b0;
    case (state_q)
      ST_ACC: begin
        // A burst that began during DUMP is never active, so its tail is ignored here.
        if (s_valid_q && (sweep_start || active_q)) begin
          active_d = !sweep_end;
          if (eff_idx < IDX_W'(NPTS)) acc_we = 1'b1;
          else                        err_len_d = 1'b1;
          if (eff_idx < IDX_W'(NPTS + 1)) idx_d = eff_idx + 1'b1;
          if (sweep_end) begin
            if (eff_idx != IDX_W'(NPTS - 1)) err_len_d = 1'b1;
            if (sweep_cnt_q == CNT_W'(MEASURES - 1)) begin
              state_d     = ST_DUMP;
              sweep_cnt_d = '0;
              rd_idx_d    = '0;
            end else begin
              sweep_cnt_d = sweep_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_DUMP: begin
        active_d = 1'b0;
        if (sweep_start) overrun_d = 1'b1;
        if (sum_ready) begin
          if (rd_idx_q == IDX_W'(NPTS - 1)) begin
            state_d  = ST_ACC;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      sweep_cnt_q <= '0;
      active_q    <= 1'b0;
      err_len_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      sweep_cnt_q <= sweep_cnt_d;
      active_q    <= active_d;
      err_len_q   <= err_len_d;
      overrun_q   <= overrun_d;
    end
  end

  // Left running through reset so a burst straddling reset release is not mistaken for a new sweep.
  always_ff @(posedge clk) begin
    s_valid_q      <= rdreq;
    s_valid_prev_q <= s_valid_q;
  end

  always_ff @(posedge clk) begin
    if (acc_we) acc_q[eff_idx] <= acc_wd;
  end

  assign sum_valid = (state_q == ST_DUMP);
  assign sum_point = 11'(rd_idx_q);
  assign sum_last  = sum_valid && (rd_idx_q == IDX_W'(NPTS - 1));
  assign sum_data  = sum_valid ? acc_q[rd_idx_q] : '0;
  assign err_len   = err_len_q;
  assign overrun   = overrun_q;
endmodule
